// File: rtl/l1b_yanitlayici_pkg.sv
// l1b_yanitlayici_pkg: shared widths and helpers for the L1 instruction
// responder slice.
//   PS_BIT             - fetch address width
//   VERI_BIT           - instruction / memory data width
//   L1B_AZAMI_BEKLEYEN - outstanding-request credit. It matches getir2's
//                        2-bit outstanding counter.
package l1b_yanitlayici_pkg;

  localparam int PS_BIT             = 32;
  localparam int VERI_BIT           = 32;
  localparam int L1B_AZAMI_BEKLEYEN = 3;

  // Memory is word addressed, so the byte offset is dropped.
  function automatic logic [PS_BIT-1:0] kelime_hizala(input logic [PS_BIT-1:0] adres);
    return {adres[PS_BIT-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/l1b_yanitlayici_buyruk_fifo.sv
// buyruk_fifo: a small circular FIFO that holds returned instruction words
// until getir2 takes them.
//   clk_i, rstn_i - clock, async active-low reset (clears pointers and count)
//   push, veri    - write veri at the tail (ignored when full)
//   pop           - drop the head (ignored when empty)
//   bas           - head word; reads 0 while empty so nothing stale leaks out
//   dolu          - occupancy
module buyruk_fifo
  import l1b_yanitlayici_pkg::*;
#(
  parameter int DERINLIK = L1B_AZAMI_BEKLEYEN,
  parameter int GENISLIK = VERI_BIT,
  localparam int SW = $clog2(DERINLIK + 1),
  localparam int PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                push,
  input  logic [GENISLIK-1:0] veri,
  input  logic                pop,
  output logic [GENISLIK-1:0] bas,
  output logic [SW-1:0]       dolu
);

  logic [GENISLIK-1:0] mem [DERINLIK];
  logic [PW-1:0]       yaz_ptr, oku_ptr;
  logic                push_ok, pop_ok;

  assign push_ok = push && (dolu != SW'(DERINLIK));
  assign pop_ok  = pop  && (dolu != '0);
  assign bas     = (dolu != '0) ? mem[oku_ptr] : '0;

  // The depth need not be a power of two, so the pointers wrap explicitly.
  function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] p);
    return (p == PW'(DERINLIK - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      dolu    <= '0;
    end else begin
      if (push_ok) yaz_ptr <= sonraki(yaz_ptr);
      if (pop_ok)  oku_ptr <= sonraki(oku_ptr);
      case ({push_ok, pop_ok})
        2'b10:   dolu <= dolu + SW'(1);
        2'b01:   dolu <= dolu - SW'(1);
        default: dolu <= dolu;
      endcase
    end
  end

  // Storage has no reset. The count and the masking on bas keep it hidden.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[yaz_ptr] <= veri;
  end

endmodule

// File: rtl/l1b_yanitlayici.sv
// l1b_yanitlayici: forwards getir1 fetch requests to backing memory and
// queues the in-order memory data for getir2. Acceptance is credit based:
// words in flight plus words queued never exceed AZAMI_BEKLEYEN.
//   clk_i, rstn_i                 - clock, async active-low reset
//   g1_istek_*                    - request from getir1 (adres/gecerli in, hazir out)
//   bellek_istek_*                - request to memory (adres/gecerli out, hazir in)
//   bellek_veri_i / _gecerli_i    - in-order read data strobe; cannot be stalled
//   g2_buyruk_*                   - instruction word to getir2 (valid/ready)
//   hata_o                        - sticky protocol error (stray or overflowing data)
module l1b_yanitlayici
  import l1b_yanitlayici_pkg::*;
#(
  parameter int AZAMI_BEKLEYEN = L1B_AZAMI_BEKLEYEN
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [PS_BIT-1:0]   g1_istek_adres_i,
  input  logic                g1_istek_gecerli_i,
  output logic                g1_istek_hazir_o,
  output logic [PS_BIT-1:0]   bellek_istek_adres_o,
  output logic                bellek_istek_gecerli_o,
  input  logic                bellek_istek_hazir_i,
  input  logic [VERI_BIT-1:0] bellek_veri_i,
  input  logic                bellek_veri_gecerli_i,
  output logic [VERI_BIT-1:0] g2_buyruk_o,
  output logic                g2_buyruk_gecerli_o,
  input  logic                g2_buyruk_hazir_i,
  output logic                hata_o
);

  localparam int SW = $clog2(AZAMI_BEKLEYEN + 1);
  localparam int BW = SW + 1;

  logic [SW-1:0] ucusta, dolu;
  logic [BW-1:0] bekleyen;
  logic          kabul, veri_ok, pop;

  assign bekleyen = {1'b0, ucusta} + {1'b0, dolu};

  // Gated by reset so no request leaks out while the block is held in reset.
  // The credit check uses registered counts only, so a pop in this cycle
  // frees its slot one cycle later.
  assign kabul = rstn_i && g1_istek_gecerli_i && bellek_istek_hazir_i &&
                 (bekleyen < BW'(AZAMI_BEKLEYEN));

  assign g1_istek_hazir_o       = kabul;
  assign bellek_istek_gecerli_o = kabul;
  assign bellek_istek_adres_o   = kelime_hizala(g1_istek_adres_i);

  // Data with nothing in flight (including leftovers from before a reset)
  // or with the queue already full is dropped.
  assign veri_ok = bellek_veri_gecerli_i && (ucusta != '0) &&
                   (dolu != SW'(AZAMI_BEKLEYEN));

  assign g2_buyruk_gecerli_o = (dolu != '0);
  assign pop                 = g2_buyruk_gecerli_o && g2_buyruk_hazir_i;

  buyruk_fifo #(
    .DERINLIK (AZAMI_BEKLEYEN),
    .GENISLIK (VERI_BIT)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (veri_ok),
    .veri   (bellek_veri_i),
    .pop    (pop),
    .bas    (g2_buyruk_o),
    .dolu   (dolu)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ucusta <= '0;
      hata_o <= 1'b0;
    end else begin
      case ({kabul, veri_ok})
        2'b10:   ucusta <= ucusta + SW'(1);
        2'b01:   ucusta <= ucusta - SW'(1);
        default: ucusta <= ucusta;
      endcase
      if (bellek_veri_gecerli_i && !veri_ok) hata_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l1b_yanitlayici.sv
// Bench for l1b_yanitlayici: directed scenarios with literal expectations,
// then a randomized run. A queue-based reference model is checked on every
// falling edge.
module tb_l1b_yanitlayici;

  localparam int AZ = 3;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] g1_istek_adres_i = '0;
  logic        g1_istek_gecerli_i = 1'b0;
  logic        g1_istek_hazir_o;
  logic [31:0] bellek_istek_adres_o;
  logic        bellek_istek_gecerli_o;
  logic        bellek_istek_hazir_i = 1'b0;
  logic [31:0] bellek_veri_i = '0;
  logic        bellek_veri_gecerli_i = 1'b0;
  logic [31:0] g2_buyruk_o;
  logic        g2_buyruk_gecerli_o;
  logic        g2_buyruk_hazir_i = 1'b0;
  logic        hata_o;

  l1b_yanitlayici dut (
    .clk_i                  (clk_i),
    .rstn_i                 (rstn_i),
    .g1_istek_adres_i       (g1_istek_adres_i),
    .g1_istek_gecerli_i     (g1_istek_gecerli_i),
    .g1_istek_hazir_o       (g1_istek_hazir_o),
    .bellek_istek_adres_o   (bellek_istek_adres_o),
    .bellek_istek_gecerli_o (bellek_istek_gecerli_o),
    .bellek_istek_hazir_i   (bellek_istek_hazir_i),
    .bellek_veri_i          (bellek_veri_i),
    .bellek_veri_gecerli_i  (bellek_veri_gecerli_i),
    .g2_buyruk_o            (g2_buyruk_o),
    .g2_buyruk_gecerli_o    (g2_buyruk_gecerli_o),
    .g2_buyruk_hazir_i      (g2_buyruk_hazir_i),
    .hata_o                 (hata_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-flight count plus a queue of returned words.
  int          m_uc = 0;
  logic [31:0] m_q[$];
  logic        m_hata = 1'b0;
  logic [31:0] mem_pend[$];   // words the bench memory still owes, in order
  logic        m_k, m_p;
  int          m_sz;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_uc = 0;
      m_q.delete();
      m_hata = 1'b0;
    end else begin
      m_k  = g1_istek_gecerli_i && bellek_istek_hazir_i && (m_uc + m_q.size() < AZ);
      m_sz = m_q.size();
      m_p  = (m_sz != 0) && g2_buyruk_hazir_i;
      if (m_p) void'(m_q.pop_front());
      if (bellek_veri_gecerli_i) begin
        if (m_uc == 0 || m_sz == AZ) m_hata = 1'b1;
        else begin
          m_q.push_back(bellek_veri_i);
          m_uc--;
        end
      end
      if (m_k) begin
        m_uc++;
        mem_pend.push_back($urandom);
      end
    end
  end

  always @(negedge clk_i) begin
    logic ek;
    ek = rstn_i && g1_istek_gecerli_i && bellek_istek_hazir_i && (m_uc + m_q.size() < AZ);
    chk("m_hazir", {31'd0, g1_istek_hazir_o}, {31'd0, ek});
    chk("m_bgec", {31'd0, bellek_istek_gecerli_o}, {31'd0, ek});
    chk("m_badr", bellek_istek_adres_o, {g1_istek_adres_i[31:2], 2'b00});
    chk("m_g2v", {31'd0, g2_buyruk_gecerli_o}, {31'd0, m_q.size() != 0});
    chk("m_g2d", g2_buyruk_o, (m_q.size() != 0) ? m_q[0] : 32'd0);
    chk("m_hata", {31'd0, hata_o}, {31'd0, m_hata});
  end

  task automatic kenar(); @(posedge clk_i); #1; endtask
  task automatic ort();   @(negedge clk_i); endtask

  int sayi;

  initial begin
    // Held in reset with a request pending: nothing may be accepted.
    g1_istek_gecerli_i = 1'b1; g1_istek_adres_i = 32'h1003; bellek_istek_hazir_i = 1'b1;
    ort();
    chk("rst_hazir", {31'd0, g1_istek_hazir_o}, 32'd0);
    chk("rst_bgec", {31'd0, bellek_istek_gecerli_o}, 32'd0);
    chk("rst_g2v", {31'd0, g2_buyruk_gecerli_o}, 32'd0);
    chk("rst_g2d", g2_buyruk_o, 32'd0);
    chk("rst_hata", {31'd0, hata_o}, 32'd0);
    kenar(); rstn_i = 1'b1;

    // Single fetch.
    ort();
    chk("tek_hazir", {31'd0, g1_istek_hazir_o}, 32'd1);
    chk("tek_adr", bellek_istek_adres_o, 32'h1000);
    kenar(); g1_istek_gecerli_i = 1'b0;
    ort(); chk("tek_bos", {31'd0, g2_buyruk_gecerli_o}, 32'd0);
    kenar(); bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'h00500093;
    ort(); chk("tek_bypass", {31'd0, g2_buyruk_gecerli_o}, 32'd0);
    kenar(); bellek_veri_gecerli_i = 1'b0; g2_buyruk_hazir_i = 1'b1;
    ort();
    chk("tek_g2v", {31'd0, g2_buyruk_gecerli_o}, 32'd1);
    chk("tek_g2d", g2_buyruk_o, 32'h00500093);
    kenar(); g2_buyruk_hazir_i = 1'b0;
    ort();
    chk("tek_son", {31'd0, g2_buyruk_gecerli_o}, 32'd0);
    chk("tek_hata", {31'd0, hata_o}, 32'd0);

    // Back-pressure: four requests with getir2 stalled.
    kenar(); g1_istek_gecerli_i = 1'b1; sayi = 0;
    for (int i = 0; i < 4; i++) begin
      g1_istek_adres_i = 32'h2000 + 32'(4 * sayi);
      ort();
      if (g1_istek_hazir_o) sayi++;
      if (i == 3) chk("bp_4_tutuldu", {31'd0, g1_istek_hazir_o}, 32'd0);
      kenar();
    end
    chk("bp_kabul", 32'(sayi), 32'd3);
    for (int k = 0; k < 3; k++) begin
      bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'hA0 + 32'(k);
      ort(); chk("bp_dolu_hazir", {31'd0, g1_istek_hazir_o}, 32'd0);
      kenar();
    end
    bellek_veri_gecerli_i = 1'b0; g2_buyruk_hazir_i = 1'b1;
    ort();
    chk("bp_pop_ayni", {31'd0, g1_istek_hazir_o}, 32'd0);
    chk("bp_bas", g2_buyruk_o, 32'hA0);
    kenar(); g2_buyruk_hazir_i = 1'b0;
    ort();
    chk("bp_sonra", {31'd0, g1_istek_hazir_o}, 32'd1);
    chk("bp_bas2", g2_buyruk_o, 32'hA1);
    kenar(); g1_istek_gecerli_i = 1'b0;
    bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'hA3; g2_buyruk_hazir_i = 1'b1;
    ort(); chk("bp_d1", g2_buyruk_o, 32'hA1);
    kenar(); bellek_veri_gecerli_i = 1'b0;
    ort(); chk("bp_d2", g2_buyruk_o, 32'hA2);
    kenar();
    ort(); chk("bp_d3", g2_buyruk_o, 32'hA3);
    kenar(); g2_buyruk_hazir_i = 1'b0;
    ort(); chk("bp_bos", {31'd0, g2_buyruk_gecerli_o}, 32'd0);

    // Accept + strobe + pop together with one word queued, one in flight.
    kenar(); g1_istek_gecerli_i = 1'b1; g1_istek_adres_i = 32'h3000;
    ort(); kenar(); g1_istek_adres_i = 32'h3004;
    ort(); kenar(); g1_istek_gecerli_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'hB0;
    ort(); kenar();
    g1_istek_gecerli_i = 1'b1; g1_istek_adres_i = 32'h3008;
    bellek_veri_i = 32'hB1; g2_buyruk_hazir_i = 1'b1;
    ort();
    chk("es_hazir", {31'd0, g1_istek_hazir_o}, 32'd1);
    chk("es_bas", g2_buyruk_o, 32'hB0);
    kenar(); g1_istek_adres_i = 32'h300C; bellek_veri_gecerli_i = 1'b0; g2_buyruk_hazir_i = 1'b0;
    ort();
    chk("es_yeni_bas", g2_buyruk_o, 32'hB1);
    chk("es_bekleyen2", {31'd0, g1_istek_hazir_o}, 32'd1);
    kenar();
    ort(); chk("es_bekleyen3", {31'd0, g1_istek_hazir_o}, 32'd0);
    kenar(); g1_istek_gecerli_i = 1'b0;
    bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'hB2; g2_buyruk_hazir_i = 1'b1;
    ort(); chk("es_d1", g2_buyruk_o, 32'hB1);
    kenar(); bellek_veri_i = 32'hB3;
    ort(); chk("es_d2", g2_buyruk_o, 32'hB2);
    kenar(); bellek_veri_gecerli_i = 1'b0;
    ort(); chk("es_d3", g2_buyruk_o, 32'hB3);
    kenar(); g2_buyruk_hazir_i = 1'b0;

    // Reset mid-flight, then a late strobe.
    g1_istek_gecerli_i = 1'b1; g1_istek_adres_i = 32'h4000;
    ort(); kenar(); g1_istek_adres_i = 32'h4004;
    ort(); kenar(); g1_istek_adres_i = 32'h4008;
    ort(); kenar(); g1_istek_gecerli_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'hC0;
    ort(); kenar(); bellek_veri_gecerli_i = 1'b0;
    g1_istek_gecerli_i = 1'b1;
    chk("rm_once", {31'd0, g2_buyruk_gecerli_o}, 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("rm_g2v", {31'd0, g2_buyruk_gecerli_o}, 32'd0);
    chk("rm_g2d", g2_buyruk_o, 32'd0);
    chk("rm_hazir", {31'd0, g1_istek_hazir_o}, 32'd0);
    chk("rm_hata", {31'd0, hata_o}, 32'd0);
    kenar(); rstn_i = 1'b1; g1_istek_gecerli_i = 1'b0;
    bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'hC1;
    ort(); chk("rm_hata_once", {31'd0, hata_o}, 32'd0);
    kenar(); bellek_veri_gecerli_i = 1'b0;
    ort();
    chk("rm_hata_son", {31'd0, hata_o}, 32'd1);
    chk("rm_g2v_son", {31'd0, g2_buyruk_gecerli_o}, 32'd0);

    // Randomized traffic against the model.
    kenar(); rstn_i = 1'b0; mem_pend.delete();
    kenar(); rstn_i = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      g1_istek_gecerli_i   = ($urandom_range(0, 3) != 0);
      g1_istek_adres_i     = $urandom;
      bellek_istek_hazir_i = ($urandom_range(0, 3) != 0);
      g2_buyruk_hazir_i    = ($urandom_range(0, 2) != 0);
      if (mem_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        bellek_veri_gecerli_i = 1'b1;
        bellek_veri_i = mem_pend.pop_front();
      end else begin
        bellek_veri_gecerli_i = 1'b0;
        bellek_veri_i = $urandom;
      end
      kenar();
    end
    g1_istek_gecerli_i = 1'b0; g2_buyruk_hazir_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_pend.size() > 0) begin
        bellek_veri_gecerli_i = 1'b1;
        bellek_veri_i = mem_pend.pop_front();
      end else bellek_veri_gecerli_i = 1'b0;
      kenar();
    end
    ort();
    chk("son_bos", {31'd0, g2_buyruk_gecerli_o}, 32'd0);
    chk("son_hata", {31'd0, hata_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
